char_console: RTL and testbench



---
 rtl/console_pkg.sv | 34 +++
 rtl/char_console.sv | 224 ++++++++++++++++++++++
 tb/tb_char_console.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared types and constants for the character console front end.
package console_pkg;

   localparam int          COLS_DEF     = 80;
   localparam int          ROWS_DEF     = 50;
   localparam logic [31:0] CLR_WORD_DEF = 32'h0000_0020;

   localparam logic [7:0] CC_CR       = 8'h0D;
   localparam logic [7:0] CC_LF       = 8'h0A;
   localparam logic [7:0] CC_BS       = 8'h08;
   localparam logic [7:0] CC_FF       = 8'h0C;
   localparam logic [7:0] PRINT_FIRST = 8'h20;
   localparam logic [7:0] PRINT_LAST  = 8'h7E;

   typedef enum logic [2:0] {
      ST_CLR,
      ST_IDLE,
      ST_PUT,
      ST_SCR_RD,
      ST_SCR_WR,
      ST_SCR_FILL
   } state_t;

   // VRAM cell layout: colour in [19:8], bit 7 reserved, 7-bit code in [6:0].
   function automatic logic [31:0] pack_word(input logic [11:0] color, input logic [6:0] code);
      return {12'h000, color, 1'b0, code};
   endfunction

   // Word index to VRAM byte address.
   function automatic logic [15:0] idx_to_addr(input logic [11:0] idx);
      return {2'b00, idx, 2'b00};
   endfunction

endpackage

// File: rtl/char_console.sv
// Byte-stream text console: cursor tracking, wrap, clear and hardware scroll
// driving the character display's local VRAM port.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_CLR      | writing CLR_WORD to every cell, idx = next cell to write
// ST_IDLE     | CH_READY=1, decoding incoming bytes
// ST_PUT      | single glyph write at the cursor, then advance cursor
// ST_SCR_RD   | RDEN at source cell idx (rows 1..ROWS-1)
// ST_SCR_WR   | WREN at idx-COLS, data forwarded from RDDATA
// ST_SCR_FILL | writing CLR_WORD across the last row, idx = cell written
module char_console
   import console_pkg::*;
#(
   parameter int          COLS     = COLS_DEF,
   parameter int          ROWS     = ROWS_DEF,
   parameter logic [31:0] CLR_WORD = CLR_WORD_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CH_VALID,
   input  logic [7:0]  CH_DATA,
   input  logic [11:0] CH_COLOR,
   output logic        CH_READY,
   output logic        BUSY,
   output logic [6:0]  CUR_X,
   output logic [5:0]  CUR_Y,
   output logic [15:0] WRADDR,
   output logic [3:0]  BYTEEN,
   output logic        WREN,
   output logic [31:0] WRDATA,
   output logic [15:0] RDADDR,
   output logic        RDEN,
   input  logic [31:0] RDDATA
);

   localparam logic [11:0] CLR_END      = 12'(ROWS * COLS);
   localparam logic [11:0] LAST_IDX     = 12'(ROWS * COLS - 1);
   localparam logic [11:0] ROW1_IDX     = 12'(COLS);
   localparam logic [11:0] LAST_ROW_IDX = 12'((ROWS - 1) * COLS);
   localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
   localparam logic [5:0]  LAST_ROW     = 6'(ROWS - 1);

   state_t      state_q, state_d;
   logic [11:0] idx_q, idx_d;
   logic [6:0]  cur_x_q, cur_x_d;
   logic [5:0]  cur_y_q, cur_y_d;
   logic        wren_q, wren_d;
   logic [15:0] wraddr_q, wraddr_d;
   logic [31:0] wrdata_q, wrdata_d;
   logic [3:0]  byteen_q, byteen_d;
   logic        fwd_q, fwd_d;
   logic        rden_q, rden_d;
   logic [15:0] rdaddr_q, rdaddr_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic [11:0] cur_idx;

   // Constant multiply by 80 folds to (row<<6)+(row<<4).
   assign cur_idx = 12'(int'(cur_y_q) * COLS + int'(cur_x_q));

   // Next-state, cursor and next-cycle strobe decisions.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      wren_d   = 1'b0;
      wraddr_d = wraddr_q;
      wrdata_d = wrdata_q;
      fwd_d    = 1'b0;
      rden_d   = 1'b0;
      rdaddr_d = rdaddr_q;

      case (state_q)
         ST_CLR: begin
            if (idx_q == CLR_END) begin
               state_d = ST_IDLE;
               cur_x_d = '0;
               cur_y_d = '0;
            end else begin
               wren_d   = 1'b1;
               wraddr_d = idx_to_addr(idx_q);
               wrdata_d = CLR_WORD;
               idx_d    = idx_q + 12'd1;
            end
         end
         ST_IDLE: begin
            if (CH_VALID) begin
               if (CH_DATA >= PRINT_FIRST && CH_DATA <= PRINT_LAST) begin
                  state_d  = ST_PUT;
                  wren_d   = 1'b1;
                  wraddr_d = idx_to_addr(cur_idx);
                  wrdata_d = pack_word(CH_COLOR, CH_DATA[6:0]);
               end else if (CH_DATA == CC_CR) begin
                  cur_x_d = '0;
               end else if (CH_DATA == CC_LF) begin
                  cur_x_d = '0;
                  if (cur_y_q < LAST_ROW) begin
                     cur_y_d = cur_y_q + 6'd1;
                  end else begin
                     state_d  = ST_SCR_RD;
                     idx_d    = ROW1_IDX;
                     rden_d   = 1'b1;
                     rdaddr_d = idx_to_addr(ROW1_IDX);
                  end
               end else if (CH_DATA == CC_BS) begin
                  if (cur_x_q != '0) cur_x_d = cur_x_q - 7'd1;
               end else if (CH_DATA == CC_FF) begin
                  // First clear write goes out on the accept edge so a
                  // form feed costs exactly ROWS*COLS busy cycles.
                  state_d  = ST_CLR;
                  wren_d   = 1'b1;
                  wraddr_d = idx_to_addr(12'd0);
                  wrdata_d = CLR_WORD;
                  idx_d    = 12'd1;
               end
            end
         end
         ST_PUT: begin
            if (cur_x_q < LAST_COL) begin
               cur_x_d = cur_x_q + 7'd1;
               state_d = ST_IDLE;
            end else if (cur_y_q < LAST_ROW) begin
               cur_x_d = '0;
               cur_y_d = cur_y_q + 6'd1;
               state_d = ST_IDLE;
            end else begin
               cur_x_d  = '0;
               state_d  = ST_SCR_RD;
               idx_d    = ROW1_IDX;
               rden_d   = 1'b1;
               rdaddr_d = idx_to_addr(ROW1_IDX);
            end
         end
         ST_SCR_RD: begin
            state_d  = ST_SCR_WR;
            wren_d   = 1'b1;
            wraddr_d = idx_to_addr(idx_q - ROW1_IDX);
            fwd_d    = 1'b1;
         end
         ST_SCR_WR: begin
            if (idx_q == LAST_IDX) begin
               state_d  = ST_SCR_FILL;
               idx_d    = LAST_ROW_IDX;
               wren_d   = 1'b1;
               wraddr_d = idx_to_addr(LAST_ROW_IDX);
               wrdata_d = CLR_WORD;
            end else begin
               state_d  = ST_SCR_RD;
               idx_d    = idx_q + 12'd1;
               rden_d   = 1'b1;
               rdaddr_d = idx_to_addr(idx_q + 12'd1);
            end
         end
         ST_SCR_FILL: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               idx_d    = idx_q + 12'd1;
               wren_d   = 1'b1;
               wraddr_d = idx_to_addr(idx_q + 12'd1);
               wrdata_d = CLR_WORD;
            end
         end
         default: begin
            state_d = ST_CLR;
            idx_d   = '0;
         end
      endcase

      byteen_d = wren_d ? 4'b0111 : 4'b0000;
      ready_d  = (state_d == ST_IDLE);
      busy_d   = (state_d == ST_CLR) || (state_d == ST_SCR_RD) ||
                 (state_d == ST_SCR_WR) || (state_d == ST_SCR_FILL);
   end

   // State, cursor and output registers; reset restarts the clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= ST_CLR;
         idx_q    <= '0;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         wren_q   <= 1'b0;
         wraddr_q <= '0;
         wrdata_q <= '0;
         byteen_q <= '0;
         fwd_q    <= 1'b0;
         rden_q   <= 1'b0;
         rdaddr_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         wren_q   <= wren_d;
         wraddr_q <= wraddr_d;
         wrdata_q <= wrdata_d;
         byteen_q <= byteen_d;
         fwd_q    <= fwd_d;
         rden_q   <= rden_d;
         rdaddr_q <= rdaddr_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign CH_READY = ready_q;
   assign BUSY     = busy_q;
   assign CUR_X    = cur_x_q;
   assign CUR_Y    = cur_y_q;
   assign WREN     = wren_q;
   assign WRADDR   = wraddr_q;
   assign BYTEEN   = byteen_q;
   assign RDEN     = rden_q;
   assign RDADDR   = rdaddr_q;
   // Scroll copy forwards the RAM's registered read port straight into the
   // write, keeping the copy at two cycles per cell.
   assign WRDATA   = fwd_q ? RDDATA : wrdata_q;

endmodule

// File: tb/tb_char_console.sv
module tb_char_console;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        CH_VALID = 1'b0;
   logic [7:0]  CH_DATA = 8'h00;
   logic [11:0] CH_COLOR = 12'h000;
   logic        CH_READY, BUSY, WREN, RDEN;
   logic [6:0]  CUR_X;
   logic [5:0]  CUR_Y;
   logic [15:0] WRADDR, RDADDR;
   logic [3:0]  BYTEEN;
   logic [31:0] WRDATA;
   logic [31:0] RDDATA;

   char_console dut (
      .CLK(CLK), .RST(RST), .CH_VALID(CH_VALID), .CH_DATA(CH_DATA), .CH_COLOR(CH_COLOR),
      .CH_READY(CH_READY), .BUSY(BUSY), .CUR_X(CUR_X), .CUR_Y(CUR_Y),
      .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WRDATA(WRDATA),
      .RDADDR(RDADDR), .RDEN(RDEN), .RDDATA(RDDATA)
   );

   always #5 CLK = ~CLK;

   // VRAM seen by the DUT: synchronous write, registered read.
   logic [31:0] vram [0:4095];
   always @(posedge CLK) begin
      if (WREN) vram[WRADDR[13:2]] <= WRDATA;
      if (RDEN) RDDATA <= vram[RDADDR[13:2]];
   end

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] exp_mem [0:4095];
   int          mx, my;
   int          checks = 0;
   int          errors = 0;
   int          n_wr, busy_cyc, cyc;
   logic [15:0] last_waddr;
   logic [31:0] last_wdata;

   function automatic logic [31:0] exp_word(input logic [11:0] c, input logic [7:0] ch);
      return {12'h000, c, 1'b0, ch[6:0]};
   endfunction

   task automatic push_wr(input int idx, input logic [31:0] d);
      wr_t e;
      e.addr = 16'(idx * 4);
      e.data = d;
      exp_q.push_back(e);
      exp_mem[idx] = d;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4000; i++) push_wr(i, 32'h0000_0020);
      mx = 0;
      my = 0;
   endtask

   task automatic model_scroll();
      for (int d = 0; d < 3920; d++) push_wr(d, exp_mem[d + 80]);
      for (int d = 3920; d < 4000; d++) push_wr(d, 32'h0000_0020);
      mx = 0;
   endtask

   task automatic model_byte(input logic [7:0] code, input logic [11:0] color);
      if (code >= 8'h20 && code <= 8'h7E) begin
         push_wr(my * 80 + mx, exp_word(color, code));
         if (mx < 79) mx++;
         else if (my < 49) begin mx = 0; my++; end
         else model_scroll();
      end else if (code == 8'h0D) begin
         mx = 0;
      end else if (code == 8'h0A) begin
         mx = 0;
         if (my < 49) my++;
         else model_scroll();
      end else if (code == 8'h08) begin
         if (mx > 0) mx--;
      end else if (code == 8'h0C) begin
         model_clear();
      end
   endtask

   // Runs cycles until the scoreboard is empty and the DUT is ready again,
   // comparing every VRAM write against the expected queue.
   task automatic drain(input int budget);
      wr_t e;
      bit  done = 1'b0;
      n_wr = 0; busy_cyc = 0; cyc = 0;
      while (!done && cyc < budget) begin
         @(negedge CLK);
         cyc++;
         if (BUSY === 1'b1) busy_cyc++;
         if (WREN === 1'b1 || RDEN === 1'b1) begin
            checks++;
            if (WREN === 1'b1 && RDEN === 1'b1) begin
               errors++;
               $display("FAIL strobe_overlap: WREN=%b RDEN=%b at cycle %0d, required not both", WREN, RDEN, cyc);
            end
         end
         if (WREN === 1'b1) begin
            n_wr++;
            last_waddr = WRADDR;
            last_wdata = WRDATA;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=%h, required no write", WRADDR, WRDATA);
            end else begin
               e = exp_q.pop_front();
               if (WRADDR !== e.addr || WRDATA !== e.data || BYTEEN !== 4'b0111) begin
                  errors++;
                  $display("FAIL vram_write: addr=%0d data=%h be=%b, required addr=%0d data=%h be=0111",
                           WRADDR, WRDATA, BYTEEN, e.addr, e.data);
               end
            end
         end
         done = (exp_q.size() == 0) && (CH_READY === 1'b1);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: %0d writes still pending after %0d cycles, required 0", exp_q.size(), cyc);
      end
   endtask

   task automatic send_byte(input logic [7:0] code, input logic [11:0] color, input int budget);
      int w = 0;
      while (CH_READY !== 1'b1 && w < 100) begin
         @(negedge CLK);
         w++;
      end
      checks++;
      if (CH_READY !== 1'b1) begin
         errors++;
         $display("FAIL ready_wait: CH_READY=%b, required 1", CH_READY);
      end
      CH_DATA  = code;
      CH_COLOR = color;
      CH_VALID = 1'b1;
      @(posedge CLK);
      #1 CH_VALID = 1'b0;
      model_byte(code, color);
      drain(budget);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      checks += 4;
      if (CH_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", CH_READY); end
      if (BUSY !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b required 1", BUSY); end
      if ({WREN, RDEN, BYTEEN} !== 6'b0) begin errors++; $display("FAIL rst_strobes: got %b required 0", {WREN, RDEN, BYTEEN}); end
      if ({WRADDR, RDADDR, WRDATA, CUR_X, CUR_Y} !== '0) begin
         errors++;
         $display("FAIL rst_regs: wa=%h ra=%h wd=%h x=%0d y=%0d required all 0", WRADDR, RDADDR, WRDATA, CUR_X, CUR_Y);
      end
      model_clear();
      RST = 1'b1;
      drain(4100);
      checks += 3;
      if (n_wr !== 4000) begin errors++; $display("FAIL clr_count: got %0d required 4000", n_wr); end
      if (cyc !== 4001) begin errors++; $display("FAIL clr_ready_cycle: got %0d required 4001", cyc); end
      if (BUSY !== 1'b0 || CH_READY !== 1'b1) begin
         errors++;
         $display("FAIL clr_done: BUSY=%b CH_READY=%b required 0/1", BUSY, CH_READY);
      end
   endtask

   task automatic test_put_a();
      send_byte(8'h41, 12'hF00, 20);
      checks += 3;
      if (last_waddr !== 16'd0 || last_wdata !== 32'h000F_0041) begin
         errors++;
         $display("FAIL put_a: addr=%0d data=%h required 0 / 000f0041", last_waddr, last_wdata);
      end
      if (cyc !== 2) begin errors++; $display("FAIL put_a_latency: got %0d cycles required 2", cyc); end
      if (CUR_X !== 7'd1 || CUR_Y !== 6'd0) begin
         errors++;
         $display("FAIL put_a_cursor: got (%0d,%0d) required (1,0)", CUR_X, CUR_Y);
      end
   endtask

   task automatic test_wrap();
      send_byte(8'h0A, 12'h000, 20);
      send_byte(8'h5A, 12'h123, 20);
      for (int i = 0; i < 9; i++) send_byte(8'h0A, 12'h000, 20);
      for (int i = 0; i < 79; i++) send_byte(8'h61 + 8'(i % 26), 12'(i * 37), 20);
      checks++;
      if (CUR_X !== 7'd79 || CUR_Y !== 6'd10) begin
         errors++;
         $display("FAIL wrap_pre: got (%0d,%0d) required (79,10)", CUR_X, CUR_Y);
      end
      send_byte(8'h42, 12'h0A5, 20);
      checks += 2;
      if (last_waddr !== 16'd3516) begin errors++; $display("FAIL wrap_addr: got %0d required 3516", last_waddr); end
      if (CUR_X !== 7'd0 || CUR_Y !== 6'd11) begin
         errors++;
         $display("FAIL wrap_cursor: got (%0d,%0d) required (0,11)", CUR_X, CUR_Y);
      end
   endtask

   task automatic test_scroll();
      for (int i = 0; i < 38; i++) send_byte(8'h0A, 12'h000, 20);
      for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 12'h0F0, 20);
      checks++;
      if (CUR_X !== 7'd5 || CUR_Y !== 6'd49) begin
         errors++;
         $display("FAIL scroll_pre: got (%0d,%0d) required (5,49)", CUR_X, CUR_Y);
      end
      send_byte(8'h0A, 12'h000, 8200);
      checks += 5;
      if (busy_cyc !== 7920) begin errors++; $display("FAIL scroll_busy: got %0d required 7920", busy_cyc); end
      if (n_wr !== 4000) begin errors++; $display("FAIL scroll_writes: got %0d required 4000", n_wr); end
      if (CUR_X !== 7'd0 || CUR_Y !== 6'd49) begin
         errors++;
         $display("FAIL scroll_cursor: got (%0d,%0d) required (0,49)", CUR_X, CUR_Y);
      end
      if (vram[0] !== 32'h0001_235A) begin errors++; $display("FAIL scroll_idx0: got %h required 0001235a", vram[0]); end
      if (vram[3999] !== 32'h0000_0020 || vram[799] !== exp_word(12'h0A5, 8'h42)) begin
         errors++;
         $display("FAIL scroll_cells: idx3999=%h idx799=%h required 00000020 / %h", vram[3999], vram[799], exp_word(12'h0A5, 8'h42));
      end
   endtask

   task automatic test_ctrl();
      logic [7:0] codes [3];
      codes[0] = 8'h08; codes[1] = 8'h0D; codes[2] = 8'h07;
      for (int i = 0; i < 3; i++) begin
         send_byte(codes[i], 12'hFFF, 20);
         checks++;
         if (cyc !== 1 || n_wr !== 0 || CUR_X !== 7'd0 || CUR_Y !== 6'd49 || CH_READY !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_%h: cyc=%0d writes=%0d cursor=(%0d,%0d) ready=%b required 1/0/(0,49)/1",
                     codes[i], cyc, n_wr, CUR_X, CUR_Y, CH_READY);
         end
      end
      for (int i = 0; i < 3; i++) send_byte(8'h78 + 8'(i), 12'h00F, 20);
      send_byte(8'h08, 12'h000, 20);
      checks++;
      if (CUR_X !== 7'(mx) || mx != 2) begin errors++; $display("FAIL bs_mid: got x=%0d required 2", CUR_X); end
      send_byte(8'h0D, 12'h000, 20);
      checks++;
      if (CUR_X !== 7'd0 || CUR_Y !== 6'd49) begin
         errors++;
         $display("FAIL cr: got (%0d,%0d) required (0,49)", CUR_X, CUR_Y);
      end
   endtask

   task automatic test_ff();
      send_byte(8'h0C, 12'h000, 4200);
      checks += 2;
      if (busy_cyc !== 4000 || n_wr !== 4000) begin
         errors++;
         $display("FAIL ff_busy: busy=%0d writes=%0d required 4000/4000", busy_cyc, n_wr);
      end
      if (CUR_X !== 7'd0 || CUR_Y !== 6'd0) begin
         errors++;
         $display("FAIL ff_cursor: got (%0d,%0d) required (0,0)", CUR_X, CUR_Y);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         send_byte(8'(32'h21 + $urandom_range(0, 93)), 12'($urandom), 20);
         checks++;
         if (cyc !== 2 || CUR_X !== 7'(mx)) begin
            errors++;
            $display("FAIL b2b_%0d: cyc=%0d x=%0d required 2/%0d", i, cyc, CUR_X, mx);
         end
      end
   endtask

   task automatic test_reset_mid_scroll();
      send_byte(8'h0D, 12'h000, 20);
      for (int i = 0; i < 49; i++) send_byte(8'h0A, 12'h000, 20);
      CH_DATA  = 8'h0A;
      CH_VALID = 1'b1;
      @(posedge CLK);
      #1 CH_VALID = 1'b0;
      repeat (200) @(negedge CLK);
      @(posedge CLK);
      #3 RST = 1'b0;
      #1;
      checks += 2;
      if ({WREN, RDEN, BYTEEN} !== 6'b0) begin
         errors++;
         $display("FAIL midrst_strobes: got %b required 0", {WREN, RDEN, BYTEEN});
      end
      if (BUSY !== 1'b1 || CH_READY !== 1'b0) begin
         errors++;
         $display("FAIL midrst_flags: BUSY=%b CH_READY=%b required 1/0", BUSY, CH_READY);
      end
      exp_q.delete();
      model_clear();
      @(negedge CLK);
      RST = 1'b1;
      drain(4100);
      checks += 2;
      if (n_wr !== 4000) begin errors++; $display("FAIL midrst_clr: got %0d writes required 4000", n_wr); end
      if (CUR_X !== 7'd0 || CUR_Y !== 6'd0) begin
         errors++;
         $display("FAIL midrst_cursor: got (%0d,%0d) required (0,0)", CUR_X, CUR_Y);
      end
   endtask

   initial begin
      mx = 0;
      my = 0;
      test_reset();
      test_put_a();
      test_wrap();
      test_scroll();
      test_ctrl();
      test_ff();
      test_back_to_back();
      test_reset_mid_scroll();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
